ks_serial_add_ctrl: RTL and testbench

//   Multi-precision add/subtract sequencer around one shared 8-bit Kogge-Stone adder slice.

---
 rtl/ks_pkg.sv | 17 +
 rtl/ks_serial_add_ctrl_if.sv | 28 ++
 rtl/ks_serial_add_ctrl_ks.sv | 24 ++
 rtl/ks_serial_add_ctrl.sv | 111 +++++++++++
 tb/tb_ks_serial_add_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ks_pkg.sv
// Shared definitions for the serial multi-precision adder controller.
package ks_pkg;

  localparam int KS_SLICE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte-index width; never narrower than one bit so NBYTES=1 still has a register.
  function automatic int idx_w(input int nbytes);
    return (nbytes <= 1) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/ks_serial_add_ctrl_if.sv
// Request/result handshake bundle between a wide requester and the serial adder.
interface ks_serial_add_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/ks_serial_add_ctrl_ks.sv
// 8-bit Kogge-Stone adder slice. c[i] is the carry out of bit i; s[8] is the slice carry out.
module kogge_stone (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [8:0] s,
  output logic [7:0] c
);
  logic [7:0] p0, g0, g1, p1, g2, p2, g3;

  // Three prefix levels (span 1, 2, 4); cin is folded into bit 0's generate.
  always_comb begin
    p0 = a ^ b;
    g0 = a & b;
    g0[0] = g0[0] | (p0[0] & cin);
    g1 = g0 | (p0 & {g0[6:0], 1'b0});
    p1 = p0 & {p0[6:0], 1'b1};
    g2 = g1 | (p1 & {g1[5:0], 2'b00});
    p2 = p1 & {p1[5:0], 2'b11};
    g3 = g2 | (p2 & {g2[3:0], 4'b0000});
    c  = g3;
    s  = {g3[7], p0 ^ {g3[6:0], cin}};
  end
endmodule

// File: rtl/ks_serial_add_ctrl.sv
// Multi-precision add/subtract sequencer: feeds one byte per cycle through a
// shared 8-bit Kogge-Stone slice, LSB first, chaining the carry in a register.
module ks_serial_add_ctrl
  import ks_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ks_serial_add_ctrl_if.slave  bus
);
  localparam int W    = KS_SLICE_W * NBYTES;
  localparam int IDXW = idx_w(NBYTES);
  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [KS_SLICE_W-1:0] slice_a, slice_b;
  logic [KS_SLICE_W:0]   ks_s;
  logic [KS_SLICE_W-1:0] ks_c;
  logic                  ks_unused;

  assign slice_a   = a_q[KS_SLICE_W*idx_q +: KS_SLICE_W];
  assign slice_b   = b_q[KS_SLICE_W*idx_q +: KS_SLICE_W];
  assign ks_unused = ^{ks_c[7], ks_c[5:0]};

  kogge_stone u_ks (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .s   (ks_s),
    .c   (ks_c)
  );

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  // Next-state, operand capture and per-byte result accumulation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.op_a;
          b_d     = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d = bus.sub;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[KS_SLICE_W*idx_q +: KS_SLICE_W] = ks_s[KS_SLICE_W-1:0];
        carry_d = ks_s[KS_SLICE_W];
        if (idx_q == LAST) begin
          cout_d  = ks_s[KS_SLICE_W];
          ovf_d   = ks_c[KS_SLICE_W-2] ^ ks_s[KS_SLICE_W];
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_ks_serial_add_ctrl.sv
// Bench for ks_serial_add_ctrl with NBYTES=4.
module tb_ks_serial_add_ctrl;
  localparam int NBYTES = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ks_serial_add_ctrl_if #(.NBYTES(NBYTES)) bus ();

  ks_serial_add_ctrl #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide integer arithmetic on unsigned and signed views.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] s, output logic co, output logic ov);
    longint ua, ub, sa, sb, ur, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      co = (ur >= 64'h1_0000_0000);
    end
    s  = ur[W-1:0];
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input bit keep_valid, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    bus.sub = sub;
    check("in_ready_before_accept", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) bus.in_valid = 1'b0;
    wait_result(lat);
  endtask

  task automatic retire();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("retire_out_valid_low", bus.out_valid, 0);
    check("retire_in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic [W-1:0] es, input logic eco,
                           input logic eov);
    int lat;
    start_op(a, b, sub, 1'b0, lat);
    check({name, "_latency"}, lat, NBYTES);
    check({name, "_sum"}, bus.sum, es);
    check({name, "_cout"}, bus.cout, eco);
    check({name, "_ovf"}, bus.ovf, eov);
    retire();
  endtask

  initial begin
    logic [W-1:0] ms;
    logic mco, mov;
    logic [W-1:0] ra, rb;
    logic rsub;
    int lat;

    vecs[0] = '{a: 32'h0000_00FF, b: 32'h0000_0001, sub: 1'b0, s: 32'h0000_0100, co: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, sub: 1'b0, s: 32'h0000_0000, co: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, sub: 1'b0, s: 32'h8000_0000, co: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 32'h8000_0000, b: 32'h0000_0001, sub: 1'b1, s: 32'h7FFF_FFFF, co: 1'b1, ov: 1'b1};
    vecs[4] = '{a: 32'h0000_0005, b: 32'h0000_0007, sub: 1'b1, s: 32'hFFFF_FFFE, co: 1'b0, ov: 1'b0};
    vecs[5] = '{a: 32'h1234_5678, b: 32'h1111_1111, sub: 1'b0, s: 32'h2345_6789, co: 1'b0, ov: 1'b0};

    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    #2;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf", bus.ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                vecs[i].s, vecs[i].co, vecs[i].ov);

    // Backpressure: result held 10 cycles with a new request pending.
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1, lat);
    check("bp_latency", lat, NBYTES);
    bus.op_a = 32'h0000_0010;
    bus.op_b = 32'h0000_0020;
    bus.sub  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_sum", bus.sum, 32'h0000_0100);
      check("bp_cout", bus.cout, 0);
      check("bp_ovf", bus.ovf, 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", bus.out_valid, 0);
    check("bp_release_busy", bus.busy, 0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("bp_next_accept", bus.busy, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result(lat);
    check("bp_next_latency", lat, NBYTES);
    model(32'h0000_0010, 32'h0000_0020, 1'b1, ms, mco, mov);
    check("bp_next_sum", bus.sum, ms);
    check("bp_next_cout", bus.cout, mco);
    check("bp_next_ovf", bus.ovf, mov);
    retire();

    // Asynchronous reset two cycles into RUN.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_a = 32'h0000_00FF;
    bus.op_b = 32'h0000_0001;
    bus.sub  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_sum", bus.sum, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_busy", bus.busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_check("after_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

    // Randomized operands against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: ra = 32'h0000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: ra = 32'h7FFF_FFFF;
        default: ra = $urandom;
      endcase
      rb   = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      rsub = 1'($urandom_range(0, 1));
      model(ra, rb, rsub, ms, mco, mov);
      run_check($sformatf("rand%0d", i), ra, rb, rsub, ms, mco, mov);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
